display_mux: RTL



---
 rtl/display_pkg.sv | 45 ++++
 rtl/display_mux_seg7_decode.sv | 30 +++
 rtl/display_mux.sv | 92 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants for the display multiplexer: digit count, core status codes
// and active-low seven-segment glyphs ordered {g,f,e,d,c,b,a}.
package display_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [1:0] ST_ERRO  = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_R     = 7'h2F;
    localparam logic [6:0] GLYPH_O     = 7'h23;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    function automatic logic [6:0] digit_glyph(input logic [3:0] value);
        logic [6:0] g;
        case (value)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/display_mux_seg7_decode.sv
// Combinational glyph selection for one digit: blank beats the error word,
// which beats the dash, which beats the numeric glyph.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    input  logic       dash,
    input  logic       err_en,
    input  logic [1:0] err_sel,
    output logic [6:0] seg
);

    always_comb begin
        seg = digit_glyph(value);
        if (blank) begin
            seg = GLYPH_BLANK;
        end else if (err_en) begin
            // err_sel is the digit position: 3..0 spell "Erro"
            case (err_sel)
                2'd3:    seg = GLYPH_E;
                2'd0:    seg = GLYPH_O;
                default: seg = GLYPH_R;
            endcase
        end else if (dash) begin
            seg = GLYPH_DASH;
        end
    end

endmodule

// File: rtl/display_mux.sv
// Captures the core's digit stream into an 8-entry buffer and scans it onto
// eight common-anode displays with leading-zero blanking and a sticky error word.
module display_mux
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    input  logic [1:0] status,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       err
);

    logic [3:0]  digit_buf_q [NUM_DIGITS];
    logic [3:0]  digit_buf_d [NUM_DIGITS];
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    logic [NUM_DIGITS-1:0] nz;
    logic [3:0]            sel_value;
    logic                  lz_blank;
    logic                  dec_blank;

    always_comb begin
        digit_buf_d = digit_buf_q;
        if (!err_q && status == ST_BUSY && pos < 4'(NUM_DIGITS)) begin
            digit_buf_d[pos[2:0]] = data;
        end
        err_d = err_q | (status == ST_ERRO);
        cnt_d = cnt_q + 16'd1;
        idx_d = idx_q;
        if (cnt_q == 16'(REFRESH_DIV - 1)) begin
            cnt_d = 16'd0;
            idx_d = idx_q + 3'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
        assign nz[gi] = |digit_buf_d[gi];
    end

    // Outputs are decoded from next-state values so a write, a scan step and
    // the error latch all reach the pins on the same edge they take effect.
    always_comb begin
        sel_value = digit_buf_d[idx_d];
        lz_blank  = BLANK_LZ && (idx_d != 3'd0) && ((nz >> idx_d) == '0);
        dec_blank = err_d ? idx_d[2] : lz_blank;
        an_d      = ~(8'd1 << idx_d);
    end

    seg7_decode u_decode (
        .value   (sel_value),
        .blank   (dec_blank),
        .dash    (sel_value > 4'd9),
        .err_en  (err_d),
        .err_sel (idx_d[1:0]),
        .seg     (seg_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_buf_q[i] <= 4'd0;
            end
            err_q <= 1'b0;
            cnt_q <= 16'd0;
            idx_q <= 3'd0;
            an_q  <= 8'hFF;
            seg_q <= GLYPH_BLANK;
        end else begin
            digit_buf_q <= digit_buf_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign err = err_q;

endmodule
